// File: rtl/cache_refill_ctrl.sv
// Memory-side refill controller for the direct-mapped L1 cache.
// It drains posted write-through stores ahead of any line refill, then
// streams the missed line from memory into the cache data array.
module cache_refill_ctrl #(
    parameter int unsigned LOG_NUM_BYTES_PER_LINE = 5,
    parameter int unsigned WB_DEPTH               = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req,
    input  logic [31:0] miss_addr,
    output logic        miss_busy,
    output logic        fill_we,
    output logic [31:0] fill_addr,
    output logic [31:0] fill_data,
    output logic        fill_done,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned WL = LOG_NUM_BYTES_PER_LINE - 2;
    localparam int unsigned PW = $clog2(WB_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << LOG_NUM_BYTES_PER_LINE) - 32'd1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          miss_pend, miss_pend_nxt;
    logic [31:0]   line_base, line_base_nxt;
    logic [WL-1:0] cnt, cnt_nxt;

    logic [31:0]   wb_addr [WB_DEPTH];
    logic [31:0]   wb_data [WB_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] wb_cnt, wb_cnt_nxt;

    logic          miss_acc, push, pop, last_word, fill_ack;
    logic          mem_req_nxt, mem_we_nxt;
    logic [31:0]   mem_addr_nxt, mem_wdata_nxt;

    assign miss_acc   = miss_req & ~miss_busy;
    assign push       = wr_req & ~wr_full;
    assign pop        = (state == WRITE) & mem_ack;
    assign fill_ack   = (state == FILL) & mem_ack;
    assign last_word  = &cnt;
    assign wb_cnt_nxt = wb_cnt + CW'(push) - CW'(pop);

    // Next-state and next bus request; stores always win over a pending miss
    always_comb begin
        state_nxt     = state;
        miss_pend_nxt = miss_pend;
        line_base_nxt = line_base;
        cnt_nxt       = cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        if (miss_acc) begin
            miss_pend_nxt = 1'b1;
            line_base_nxt = miss_addr & LINE_MASK;
        end

        case (state)
            IDLE: begin
                if (wb_cnt != '0) begin
                    state_nxt     = WRITE;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = wb_addr[rd_ptr];
                    mem_wdata_nxt = wb_data[rd_ptr];
                end else if (miss_pend_nxt) begin
                    state_nxt    = FILL;
                    cnt_nxt      = '0;
                    mem_req_nxt  = 1'b1;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = line_base_nxt;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    state_nxt   = IDLE;
                    mem_req_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cnt_nxt = cnt + WL'(1);
                    if (last_word) begin
                        state_nxt     = IDLE;
                        miss_pend_nxt = 1'b0;
                        mem_req_nxt   = 1'b0;
                    end else begin
                        mem_addr_nxt = line_base | 32'({cnt_nxt, 2'b00});
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
                mem_we_nxt  = 1'b0;
            end
        endcase
    end

    // State, control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            miss_pend <= 1'b0;
            line_base <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wb_cnt    <= '0;
            wr_full   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fill_we   <= 1'b0;
            fill_done <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
            miss_busy <= 1'b0;
        end else begin
            state     <= state_nxt;
            miss_pend <= miss_pend_nxt;
            line_base <= line_base_nxt;
            cnt       <= cnt_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            wb_cnt    <= wb_cnt_nxt;
            wr_full   <= (wb_cnt_nxt == CW'(WB_DEPTH));
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            fill_we   <= fill_ack;
            fill_done <= fill_ack & last_word;
            if (fill_ack) begin
                fill_addr <= mem_addr;
                fill_data <= mem_rdata;
            end
            if (miss_acc) begin
                miss_busy <= 1'b1;
            end else if (fill_done) begin
                miss_busy <= 1'b0;
            end
        end
    end

    // Posted-write storage; contents are meaningless once the count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= wr_addr;
            wb_data[wr_ptr] <= wr_data;
        end
    end

endmodule
